stall_controller: RTL

Pipeline stall/flush controller for the 5-stage ARM core. It sits between the ID-stage hazard detector, the EX-stage branch logic and the MEM-stage SRAM interface, and drives the hold/clear controls of PC, IF/ID, ID/EX and the later pipeline registers. It tracks IF/ID validity so that hazards raised by flushed slots are ignored. It also keeps stall/flush statistics and watchdog flags.

---
 rtl/stall_controller_pkg.sv | 24 ++
 rtl/stall_controller_sat_counter.sv | 27 ++
 rtl/stall_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stall_controller_pkg.sv
// rtl/stall_controller_pkg.sv - shared types and default constants for the stall controller
package stall_controller_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic freeze_if;
        logic flush_if_id;
        logic bubble_id_ex;
        logic freeze_all;
    } ctrl_t;

    localparam int DEF_COUNT_W     = 16;
    localparam int DEF_MAX_HAZARD  = 2;
    localparam int DEF_MEM_TIMEOUT = 255;

    // Widths of the internal watchdog run-length counters (they saturate).
    localparam int HZ_RUN_W   = 8;
    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/stall_controller_sat_counter.sv
// rtl/stall_controller_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [COUNT_W-1:0] o_count
);

    logic [COUNT_W-1:0] r_count;

    // Clear beats increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/stall_controller.sv
// rtl/stall_controller.sv - pipeline hold/flush control with statistics and watchdogs
module stall_controller
    import stall_controller_pkg::*;
#(
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int MAX_HAZARD  = DEF_MAX_HAZARD,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard,
    input  logic               branch_taken,
    input  logic               mem_req,
    input  logic               mem_ready,
    input  logic               clr_stats,
    output logic               freeze_if,
    output logic               flush_if_id,
    output logic               bubble_id_ex,
    output logic               freeze_all,
    output logic [COUNT_W-1:0] stall_cycles,
    output logic [COUNT_W-1:0] flush_count,
    output logic               hazard_timeout,
    output logic               mem_timeout
);

    // Flag fires on the edge that closes the MAX_HAZARD-th consecutive hazard cycle.
    localparam logic [HZ_RUN_W-1:0]   HZ_LIMIT   = HZ_RUN_W'(MAX_HAZARD - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_id_valid;
    logic [HZ_RUN_W-1:0]     r_hz_run;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    r_hazard_timeout;
    logic                    r_mem_timeout;

    logic                    w_mem_stall;
    logic                    w_hazard_eff;
    logic                    w_hazard_row;
    ctrl_t                   w_ctrl;

    assign w_mem_stall  = mem_req & ~mem_ready;
    // A hazard reported for a flushed (bubble) slot is meaningless.
    assign w_hazard_eff = hazard & r_id_valid;
    assign w_hazard_row = ~w_mem_stall & ~branch_taken & w_hazard_eff;

    // Priority encode the pipeline controls: memory stall, then branch, then hazard.
    always_comb begin
        w_ctrl = '0;
        if (w_mem_stall) begin
            w_ctrl.freeze_all = 1'b1;
            w_ctrl.freeze_if  = 1'b1;
        end else if (branch_taken) begin
            w_ctrl.flush_if_id  = 1'b1;
            w_ctrl.bubble_id_ex = 1'b1;
        end else if (w_hazard_eff) begin
            w_ctrl.freeze_if    = 1'b1;
            w_ctrl.bubble_id_ex = 1'b1;
        end
    end

    // State register for the memory wait FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: enter MEM_WAIT on a stalled access, leave on the first ready.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_mem_stall) w_state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ready)   w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    // IF/ID validity follows the slot: held while frozen, killed by a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid <= 1'b0;
        end else if (w_ctrl.freeze_if || w_ctrl.freeze_all) begin
            r_id_valid <= r_id_valid;
        end else if (w_ctrl.flush_if_id) begin
            r_id_valid <= 1'b0;
        end else begin
            r_id_valid <= 1'b1;
        end
    end

    // Hazard watchdog: length of the current run of hazard-row cycles plus sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hz_run         <= '0;
            r_hazard_timeout <= 1'b0;
        end else begin
            if (w_hazard_row) begin
                if (r_hz_run != '1) r_hz_run <= r_hz_run + 1'b1;
                if (r_hz_run >= HZ_LIMIT) r_hazard_timeout <= 1'b1;
            end else begin
                r_hz_run <= '0;
            end
        end
    end

    // Memory watchdog: cycles already spent waiting in MEM_WAIT plus sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if ((r_state == MEM_WAIT) && !mem_ready) begin
                if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_wait_cnt >= WAIT_LIMIT) r_mem_timeout <= 1'b1;
        end
    end

    sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_ctrl.freeze_if),
        .i_clr   (clr_stats),
        .o_count (stall_cycles)
    );

    sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_ctrl.flush_if_id),
        .i_clr   (clr_stats),
        .o_count (flush_count)
    );

    assign freeze_if      = w_ctrl.freeze_if;
    assign flush_if_id    = w_ctrl.flush_if_id;
    assign bubble_id_ex   = w_ctrl.bubble_id_ex;
    assign freeze_all     = w_ctrl.freeze_all;
    assign hazard_timeout = r_hazard_timeout;
    assign mem_timeout    = r_mem_timeout;

endmodule
